// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier.
// Produces a registered one-cycle writeback strobe for the register file.
module exec_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     operandA,
    input  logic [DATA_W-1:0]     operandB,
    input  logic [REG_ADDR_W-1:0] destReg,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic                  zero
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int SHW   = $clog2(DATA_W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MUL  = 1'b1;

    logic                  r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_acc;
    logic [DATA_W-1:0]     r_mcand;
    logic [DATA_W-1:0]     r_mplier;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;
    logic                  r_zero;

    logic                  w_accept;
    logic [DATA_W-1:0]     w_alu;
    logic [DATA_W-1:0]     w_sum;

    assign in_ready  = (r_state == ST_IDLE) && !reset;
    assign w_accept  = in_valid && in_ready;
    assign regWrite  = r_reg_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;
    assign zero      = r_zero;

    // Accumulator value after the current multiply iteration.
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_alu = '0;
        case (op)
            OP_ADD:  w_alu = operandA + operandB;
            OP_SUB:  w_alu = operandA - operandB;
            OP_AND:  w_alu = operandA & operandB;
            OP_OR:   w_alu = operandA | operandB;
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            OP_SLL:  w_alu = operandA << operandB[SHW-1:0];
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_dest       <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_zero       <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (op == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= operandA;
                            r_mplier <= operandB;
                            r_dest   <= destReg;
                            r_cnt    <= CNT_W'(DATA_W - 1);
                            r_state  <= ST_MUL;
                        end else if (op != OP_NOP) begin
                            r_write_data <= w_alu;
                            r_write_reg  <= destReg;
                            r_reg_write  <= 1'b1;
                            r_zero       <= (w_alu == '0);
                        end
                    end
                end
                default: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_write_data <= w_sum;
                        r_write_reg  <= r_dest;
                        r_reg_write  <= 1'b1;
                        r_zero       <= (w_sum == '0);
                        r_state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus pushes expected writebacks,
// a negedge monitor pops and compares each regWrite pulse.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b111;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic [1:0]  destReg = '0;
    logic        regWrite;
    logic [1:0]  writeReg;
    logic [31:0] writeData;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  r;
        logic [31:0] d;
        logic        z;
    } exp_t;

    exp_t q[$];

    exec_unit #(.DATA_W(32), .REG_ADDR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .destReg   (destReg),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && regWrite) begin
            if (q.size() == 0) begin
                chk("unexpected_writeback", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("writeReg", 32'(writeReg), 32'(e.r));
                chk("writeData", writeData, e.d);
                chk("zero", 32'(zero), 32'(e.z));
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] d, input logic wb, input logic [31:0] ed);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        op = o; operandA = a; operandB = b; destReg = d; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        if (wb) begin
            e.r = d; e.d = ed; e.z = (ed == 32'd0);
            q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int busy;
        exp_t e;
        #1;
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_writeReg", 32'(writeReg), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("idle_in_ready", 32'(in_ready), 32'd1);

        send(3'b000, 32'd5, 32'd7, 2'd2, 1'b1, 32'd12);
        @(negedge clk);
        @(negedge clk);
        chk("single_pulse", 32'(regWrite), 32'd0);

        // Back-to-back single-cycle ops.
        send(3'b001, 32'd3, 32'd3, 2'd1, 1'b1, 32'd0);
        send(3'b100, 32'hFFFFFFFF, 32'd1, 2'd3, 1'b1, 32'd1);
        send(3'b110, 32'd1, 32'd31, 2'd0, 1'b1, 32'h80000000);
        send(3'b110, 32'd3, 32'h21, 2'd2, 1'b1, 32'd6);
        send(3'b100, 32'd1, 32'hFFFFFFFF, 2'd1, 1'b1, 32'd0);
        drain();

        // MUL with an ADD held on in_valid during the busy window.
        send(3'b101, 32'h0000FFFF, 32'h00010001, 2'd1, 1'b1, 32'hFFFFFFFF);
        @(negedge clk);
        op = 3'b000; operandA = 32'h10; operandB = 32'h20; destReg = 2'd3; in_valid = 1'b1;
        busy = 0;
        while (!in_ready && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", 32'(busy), 32'd32);
        chk("mul_done_pulse", 32'(regWrite), 32'd1);
        e.r = 2'd3; e.d = 32'h30; e.z = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        send(3'b101, 32'h80000000, 32'd2, 2'd2, 1'b1, 32'd0);
        send(3'b101, 32'h12345678, 32'd0, 2'd3, 1'b1, 32'd0);
        send(3'b010, 32'hF0F0FF00, 32'h0FF0F0F0, 2'd0, 1'b1, 32'h00F0F000);
        send(3'b011, 32'hF0000000, 32'h0000000F, 2'd1, 1'b1, 32'hF000000F);
        drain();

        // Asynchronous reset in the middle of a multiply.
        send(3'b101, 32'd9, 32'd9, 2'd2, 1'b0, 32'd0);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_writeData", writeData, 32'd0);
        chk("async_rst_writeReg", 32'(writeReg), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_wb_after_rst", 32'(writeData), 32'd0);
        send(3'b000, 32'd1, 32'd1, 2'd1, 1'b1, 32'd2);
        drain();

        // NOP: accepted, no writeback, outputs hold.
        send(3'b111, 32'd100, 32'd200, 2'd3, 1'b0, 32'd0);
        chk("nop_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("nop_regWrite", 32'(regWrite), 32'd0);
        chk("nop_hold_data", writeData, 32'd2);
        chk("nop_hold_reg", 32'(writeReg), 32'd1);
        repeat (3) @(negedge clk);
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
